mipi_csi_tx_packetizer: RTL and testbench

Transmit-side counterpart of the CSI-2 receive chain (byte aligner / lane aligner / packet decoder). Accepts packet requests plus a 32-bit payload stream and emits a 4-lane HS byte stream: sync byte, packet header with ECC, payload, and CRC16 footer, followed by an inter-packet gap. Drives a D-PHY TX serializer in a sensor-emulator / loopback test path.

---
 rtl/mipi_csi_tx_pkg.sv | 53 +++++
 rtl/mipi_csi_crc16_x32.sv | 47 ++++
 rtl/mipi_csi_tx_packetizer.sv | 193 +++++++++++++++++++
 tb/tb_mipi_csi_tx_packetizer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_tx_pkg.sv
// Shared constants, state encoding and header/checksum helpers for the CSI-2 TX packetizer.
package mipi_csi_tx_pkg;

  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_LS        = 6'h02;
  localparam logic [5:0] DT_LE        = 6'h03;
  localparam logic [5:0] DT_RAW8      = 6'h2A;
  localparam logic [5:0] DT_RAW10     = 6'h2B;
  localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

  // Parity Pi covers the header bits set in ECC_MASK_Pi, D[23:0] = {wc_hi, wc_lo, DI}.
  localparam logic [23:0] ECC_MASK_P0 = 24'hF12CB7;
  localparam logic [23:0] ECC_MASK_P1 = 24'hF2555B;
  localparam logic [23:0] ECC_MASK_P2 = 24'h749A6D;
  localparam logic [23:0] ECC_MASK_P3 = 24'hB8E38E;
  localparam logic [23:0] ECC_MASK_P4 = 24'hDF03F0;
  localparam logic [23:0] ECC_MASK_P5 = 24'hEFFC00;

  localparam logic [15:0] CRC16_POLY = 16'h8408;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR,
    ST_PAY,
    ST_FTR,
    ST_GAP
  } tx_state_e;

  function automatic logic [5:0] csi_ecc(input logic [23:0] d);
    logic [5:0] e;
    e[0] = ^(d & ECC_MASK_P0);
    e[1] = ^(d & ECC_MASK_P1);
    e[2] = ^(d & ECC_MASK_P2);
    e[3] = ^(d & ECC_MASK_P3);
    e[4] = ^(d & ECC_MASK_P4);
    e[5] = ^(d & ECC_MASK_P5);
    return e;
  endfunction

  // Reflected CRC16: one byte, least significant bit first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mipi_csi_crc16_x32.sv
// Four-bytes-per-cycle CRC16 (reflected 0x8408) with synchronous clear and enable.
// Only built when MIPI_TX_CRC_EN is defined; otherwise the footer carries zero.
`ifdef MIPI_TX_CRC_EN
module mipi_csi_crc16_x32
  import mipi_csi_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] data,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;
  logic [15:0] crc_next;
  logic [15:0] crc_step;

  // Lane 0 is the earliest byte on the wire, so it is folded in first.
  always_comb begin
    crc_step = crc_reg;
    for (int i = 0; i < 4; i++) begin
      crc_step = crc16_byte(crc_step, data[8*i +: 8]);
    end
  end

  always_comb begin
    crc_next = crc_reg;
    if (clr) begin
      crc_next = CRC16_INIT;
    end else if (en) begin
      crc_next = crc_step;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      crc_reg <= CRC16_INIT;
    end else begin
      crc_reg <= crc_next;
    end
  end

  assign crc = crc_reg;

endmodule
`endif

// File: rtl/mipi_csi_tx_packetizer.sv
// CSI-2 4-lane HS packetizer: sync, header+ECC, payload, CRC16 footer, inter-packet gap.
// Build option MIPI_TX_CRC_EN: computes the footer checksum; when undefined the footer is 16'h0000.
module mipi_csi_tx_packetizer
  import mipi_csi_tx_pkg::*;
#(
  parameter int         GAP_CYCLES = 8,
  parameter logic [7:0] SYNC_BYTE  = 8'hB8
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        pkt_req_i,
  input  logic [1:0]  pkt_vc_i,
  input  logic [5:0]  pkt_dt_i,
  input  logic [15:0] pkt_wc_i,
  output logic        pkt_ack_o,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic [31:0] lane_data_o,
  output logic [3:0]  lane_valid_o,
  output logic        hs_active_o,
  output logic        err_o
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  tx_state_e         state_reg, state_next;
  logic [1:0]        vc_reg, vc_next;
  logic [5:0]        dt_reg, dt_next;
  logic [15:0]       wc_reg, wc_next;
  logic [13:0]       cnt_reg, cnt_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic [31:0]       lane_data_reg, lane_data_next;
  logic [3:0]        lane_valid_reg, lane_valid_next;
  logic              hs_reg, hs_next;
  logic              ack_reg, ack_next;
  logic              err_reg, err_next;

  logic [31:0] sync_word;
  logic [31:0] pay_word;
  logic [5:0]  hdr_ecc;
  logic [15:0] crc_value;
  logic        is_short;
  logic        req_bad_wc;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      assign sync_word[8*gi +: 8] = SYNC_BYTE;
    end
  endgenerate

  // An underrun still consumes a word slot; zeros go on the wire and into the CRC.
  assign pay_word   = data_valid_i ? data_i : 32'h0000_0000;
  assign hdr_ecc    = csi_ecc({wc_reg, vc_reg, dt_reg});
  assign is_short   = (dt_reg <= DT_SHORT_MAX);
  assign req_bad_wc = (pkt_dt_i > DT_SHORT_MAX) && (pkt_wc_i[1:0] != 2'b00);

`ifdef MIPI_TX_CRC_EN
  mipi_csi_crc16_x32 u_crc (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr       (state_reg == ST_SYNC),
    .en        (state_reg == ST_PAY),
    .data      (pay_word),
    .crc       (crc_value)
  );
`else
  assign crc_value = 16'h0000;
`endif

  always_comb begin
    state_next      = state_reg;
    vc_next         = vc_reg;
    dt_next         = dt_reg;
    wc_next         = wc_reg;
    cnt_next        = cnt_reg;
    gap_next        = gap_reg;
    lane_data_next  = 32'h0000_0000;
    lane_valid_next = 4'h0;
    hs_next         = 1'b0;
    ack_next        = 1'b0;
    err_next        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // The ack guard keeps a request still high in the ack cycle from being taken twice.
        if (pkt_req_i && !ack_reg) begin
          ack_next = 1'b1;
          if (req_bad_wc) begin
            err_next = 1'b1;
          end else begin
            vc_next    = pkt_vc_i;
            dt_next    = pkt_dt_i;
            wc_next    = pkt_wc_i;
            state_next = ST_SYNC;
          end
        end
      end

      ST_SYNC: begin
        lane_data_next  = sync_word;
        lane_valid_next = 4'hF;
        hs_next         = 1'b1;
        state_next      = ST_HDR;
      end

      ST_HDR: begin
        lane_data_next  = {2'b00, hdr_ecc, wc_reg[15:8], wc_reg[7:0], vc_reg, dt_reg};
        lane_valid_next = 4'hF;
        hs_next         = 1'b1;
        cnt_next        = wc_reg[15:2];
        if (is_short) begin
          gap_next   = GAP_W'(GAP_CYCLES);
          state_next = ST_GAP;
        end else if (wc_reg[15:2] == 14'd0) begin
          state_next = ST_FTR;
        end else begin
          state_next = ST_PAY;
        end
      end

      ST_PAY: begin
        lane_data_next  = pay_word;
        lane_valid_next = 4'hF;
        hs_next         = 1'b1;
        err_next        = !data_valid_i;
        if (cnt_reg == 14'd1) begin
          state_next = ST_FTR;
        end else begin
          cnt_next = cnt_reg - 14'd1;
        end
      end

      ST_FTR: begin
        lane_data_next  = {16'h0000, crc_value};
        lane_valid_next = 4'b0011;
        hs_next         = 1'b1;
        gap_next        = GAP_W'(GAP_CYCLES);
        state_next      = ST_GAP;
      end

      ST_GAP: begin
        if (gap_reg <= GAP_W'(1)) begin
          gap_next   = '0;
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg      <= ST_IDLE;
      vc_reg         <= '0;
      dt_reg         <= '0;
      wc_reg         <= '0;
      cnt_reg        <= '0;
      gap_reg        <= '0;
      lane_data_reg  <= '0;
      lane_valid_reg <= '0;
      hs_reg         <= 1'b0;
      ack_reg        <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      vc_reg         <= vc_next;
      dt_reg         <= dt_next;
      wc_reg         <= wc_next;
      cnt_reg        <= cnt_next;
      gap_reg        <= gap_next;
      lane_data_reg  <= lane_data_next;
      lane_valid_reg <= lane_valid_next;
      hs_reg         <= hs_next;
      ack_reg        <= ack_next;
      err_reg        <= err_next;
    end
  end

  assign pkt_ack_o    = ack_reg;
  assign err_o        = err_reg;
  assign lane_data_o  = lane_data_reg;
  assign lane_valid_o = lane_valid_reg;
  assign hs_active_o  = hs_reg;
  assign data_ready_o = (state_reg == ST_PAY);

endmodule

// File: tb/tb_mipi_csi_tx_packetizer.sv
// Directed bench for the CSI-2 TX packetizer: headers/ECC, payload, footer, gap, errors, reset.
`timescale 1ns/1ps
module tb_mipi_csi_tx_packetizer;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        pkt_req_i;
  logic [1:0]  pkt_vc_i;
  logic [5:0]  pkt_dt_i;
  logic [15:0] pkt_wc_i;
  logic        pkt_ack_o;
  logic [31:0] data_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [31:0] lane_data_o;
  logic [3:0]  lane_valid_o;
  logic        hs_active_o;
  logic        err_o;

  int n_vec = 0;
  int n_err = 0;

`ifdef MIPI_TX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  localparam logic [15:0] CRC_EMPTY = CRC_ON ? 16'hFFFF : 16'h0000;
  localparam logic [15:0] CRC_VEC   = CRC_ON ? 16'h00F0 : 16'h0000;

  // Payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01.
  logic [31:0] pay_mem [6] = '{32'h020000FF, 32'h72F3DCB9, 32'h5AB8D4BB,
                               32'h7CC275C8, 32'hDF05F881, 32'h010000FF};

  // ECC of a header with only bit k of D[23:0] set.
  logic [5:0] ecc_col [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                               6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                               6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  mipi_csi_tx_packetizer #(.GAP_CYCLES(8), .SYNC_BYTE(8'hB8)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .pkt_req_i    (pkt_req_i),
    .pkt_vc_i     (pkt_vc_i),
    .pkt_dt_i     (pkt_dt_i),
    .pkt_wc_i     (pkt_wc_i),
    .pkt_ack_o    (pkt_ack_o),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .lane_data_o  (lane_data_o),
    .lane_valid_o (lane_valid_o),
    .hs_active_o  (hs_active_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk_i);
      if (pkt_ack_o) ok = 1'b1;
    end
    if (!ok) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic tx_packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                           input logic [5:0] ecc, input logic [15:0] crc, input bit crc_known,
                           input int drop);
    int nw;
    bit is_long;
    bit ok;
    is_long = (dt > 6'h0F);
    nw      = is_long ? int'(wc[15:2]) : 0;
    $display("tx vc=%0d dt=%02h wc=%04h words=%0d drop=%0d", vc, dt, wc, nw, drop);
    @(negedge clk_i);
    pkt_vc_i  = vc;
    pkt_dt_i  = dt;
    pkt_wc_i  = wc;
    pkt_req_i = 1'b1;
    wait_ack(ok);
    pkt_req_i = 1'b0;
    if (!ok) return;
    chk("ack_err", err_o, 0);
    @(negedge clk_i);
    chk("sync_data", lane_data_o, 32'hB8B8B8B8);
    chk("sync_valid", lane_valid_o, 4'hF);
    chk("sync_hs", hs_active_o, 1);
    @(negedge clk_i);
    chk("hdr_data", lane_data_o, {2'b00, ecc, wc[15:8], wc[7:0], vc, dt});
    chk("hdr_valid", lane_valid_o, 4'hF);
    chk("hdr_ready", data_ready_o, (nw > 0) ? 1 : 0);
    if (nw > 0) begin
      data_i       = pay_mem[0];
      data_valid_i = (drop != 0);
    end
    for (int i = 0; i < nw; i++) begin
      @(negedge clk_i);
      chk("pay_data", lane_data_o, (i == drop) ? 32'h0 : pay_mem[i]);
      chk("pay_err", err_o, (i == drop) ? 1 : 0);
      chk("pay_valid", lane_valid_o, 4'hF);
      if (i + 1 < nw) begin
        data_i       = pay_mem[i+1];
        data_valid_i = (i + 1 != drop);
      end else begin
        data_i       = 32'h0;
        data_valid_i = 1'b0;
      end
    end
    if (is_long) begin
      @(negedge clk_i);
      if (crc_known) chk("ftr_data", lane_data_o, {16'h0000, crc});
      chk("ftr_valid", lane_valid_o, 4'b0011);
      chk("ftr_hs", hs_active_o, 1);
      chk("ftr_ready", data_ready_o, 0);
    end
    for (int g = 0; g < 8; g++) begin
      @(negedge clk_i);
      chk("gap_hs", hs_active_o, 0);
      chk("gap_valid", lane_valid_o, 0);
      chk("gap_data", lane_data_o, 0);
      chk("gap_ready", data_ready_o, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  v;
    logic [5:0]  d;
    logic [15:0] w;
    bit          ok;

    reset_n_i    = 1'b0;
    pkt_req_i    = 1'b0;
    pkt_vc_i     = '0;
    pkt_dt_i     = '0;
    pkt_wc_i     = '0;
    data_i       = '0;
    data_valid_i = 1'b0;
    #2;
    chk("rst_data", lane_data_o, 0);
    chk("rst_valid", lane_valid_o, 0);
    chk("rst_hs", hs_active_o, 0);
    chk("rst_ack", pkt_ack_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", data_ready_o, 0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;

    // Frame start short packet and the all-zero header.
    tx_packet(2'd0, 6'h00, 16'h0001, 6'h1A, 16'h0, 1'b0, -1);
    tx_packet(2'd0, 6'h00, 16'h0000, 6'h00, 16'h0, 1'b0, -1);

    // One header bit at a time; DT bits 4 and 5 make zero-length long packets.
    for (int k = 0; k < 24; k++) begin
      v = '0;
      d = '0;
      w = '0;
      if (k < 6)      d = 6'(1 << k);
      else if (k < 8) v = 2'(1 << (k - 6));
      else            w = 16'(1 << (k - 8));
      tx_packet(v, d, w, ecc_col[k], CRC_EMPTY, 1'b1, -1);
    end

    tx_packet(2'd0, 6'h2A, 16'd24, 6'h13, CRC_VEC, 1'b1, -1);
    tx_packet(2'd0, 6'h2A, 16'd0, 6'h10, CRC_EMPTY, 1'b1, -1);

    // Long packet with word count not a multiple of 4.
    $display("tx bad wc vc=0 dt=2a wc=0006");
    @(negedge clk_i);
    pkt_dt_i  = 6'h2A;
    pkt_wc_i  = 16'd6;
    pkt_req_i = 1'b1;
    wait_ack(ok);
    pkt_req_i = 1'b0;
    if (ok) chk("bad_wc_err", err_o, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("bad_wc_hs", hs_active_o, 0);
      chk("bad_wc_valid", lane_valid_o, 0);
      chk("bad_wc_ack", pkt_ack_o, 0);
    end

    // Underrun on the third of four words; CRC only hand-known when zeroed.
    tx_packet(2'd0, 6'h2A, 16'd16, 6'h36, 16'h0000, !CRC_ON, 2);

    // Reset while payload is on the wire.
    $display("tx reset mid-payload vc=0 dt=2a wc=0018");
    @(negedge clk_i);
    pkt_dt_i  = 6'h2A;
    pkt_wc_i  = 16'd24;
    pkt_req_i = 1'b1;
    wait_ack(ok);
    pkt_req_i    = 1'b0;
    data_i       = pay_mem[0];
    data_valid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("pre_rst_data", lane_data_o, pay_mem[0]);
    #2 reset_n_i = 1'b0;
    #1;
    chk("mid_rst_data", lane_data_o, 0);
    chk("mid_rst_valid", lane_valid_o, 0);
    chk("mid_rst_hs", hs_active_o, 0);
    chk("mid_rst_ready", data_ready_o, 0);
    chk("mid_rst_err", err_o, 0);
    @(negedge clk_i);
    reset_n_i    = 1'b1;
    data_valid_i = 1'b0;
    data_i       = '0;
    tx_packet(2'd0, 6'h00, 16'h0001, 6'h1A, 16'h0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
